// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the divider. The master issues operands and a
// start pulse; the slave (the divider) returns status and results.
interface seq_divider_if #(
  parameter int WIDTH = seq_divider_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_sub_stage.sv
// Combinational N-bit compare/subtract built as a ripple chain of
// full-subtractor cells. diff_o = a_i - b_i; ge_o is high when a_i >= b_i
// (no borrow out of the top cell).
module sub_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         ge_o
);

  logic [N:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    // Full-subtractor cell: difference and borrow-out for one bit.
    assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
    assign borrow[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
  end

  assign ge_o = ~borrow[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock using a single
// shared compare/subtract stage. Results are registered in DONE and
// announced by a one-cycle done strobe in the following cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;       // partial quotient / shifting dividend
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder, always < D between steps
  logic [WIDTH-1:0] d_q, d_d;       // captured divisor
  logic [CW-1:0]    cnt_q, cnt_d;   // steps left in RUN
  logic             dz_q, dz_d;     // current division has a zero divisor
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             unused_diff_msb;

  // The shifted remainder needs the extra bit; after a restoring step it is
  // back below D, so the stored remainder only needs WIDTH bits.
  assign r_shift         = {r_q, q_q[WIDTH-1]};
  assign unused_diff_msb = diff[WIDTH];

  sub_stage #(.N(WIDTH + 1)) u_sub_stage (
    .a_i    (r_shift),
    .b_i    ({1'b0, d_q}),
    .diff_o (diff),
    .ge_o   (ge)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start in the done-strobe cycle is ignored.
        if (bus.start && !done_q) begin
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            r_d     = '0;
            d_d     = bus.divisor;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = bus.dividend;
            d_d     = '0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        r_d   = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        quot_d  = q_q;
        rem_d   = r_q;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // busy covers RUN, DONE and the done-strobe cycle, so it falls with done.
  assign bus.busy        = (state_q != IDLE) || done_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
